// File: rtl/freelist_pkg.sv
// Shared constants and pointer helpers for the rename-stage physical register free list.
package freelist_pkg;

  localparam int unsigned PREG_NUM = 64;
  localparam int unsigned LREG_NUM = 32;
  localparam int unsigned FL_DEPTH = PREG_NUM - LREG_NUM;
  localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  // Index plus wrap bit, so full and empty are distinguishable.
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t ptr, input logic [1:0] n);
    return ptr + fl_ptr_t'(n);
  endfunction

endpackage

// File: rtl/freelist.sv
// Dual-ported circular free list of physical registers with flush-restorable speculative head.
// Optional stall-cycle counter enabled by defining FREELIST_STALL_CNT_EN.
module freelist #(
  parameter int unsigned PREG_NUM = 64,
  parameter int unsigned LREG_NUM = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        instr0_freelist_req,
  output logic [$clog2(PREG_NUM)-1:0] instr0_freelist_resp,
  input  logic                        instr1_freelist_req,
  output logic [$clog2(PREG_NUM)-1:0] instr1_freelist_resp,
  output logic                        freelist_stall,
  input  logic                        commit_instr0_free_valid,
  input  logic [$clog2(PREG_NUM)-1:0] commit_instr0_free_preg,
  input  logic                        commit_instr1_free_valid,
  input  logic [$clog2(PREG_NUM)-1:0] commit_instr1_free_preg,
  input  logic                        flush_valid,
  output logic [5:0]                  freelist_count
`ifdef FREELIST_STALL_CNT_EN
  ,
  output logic [31:0]                 freelist_stall_cycles
`endif
);

  import freelist_pkg::*;

  localparam int unsigned Depth = PREG_NUM - LREG_NUM;
  localparam int unsigned PregW = $clog2(PREG_NUM);
  localparam int unsigned IdxW  = $clog2(Depth);

  typedef logic [IdxW-1:0] idx_t;

  logic [PregW-1:0] entry_q [Depth];

  fl_ptr_t    head_q, head_d;
  fl_ptr_t    tail_q, tail_d;
  fl_ptr_t    arch_head_q, arch_head_d;
  logic [5:0] count_q, count_d;

  logic [1:0] need;
  logic [1:0] nfree;
  logic       fire;
  idx_t       head_idx, head_idx1;
  idx_t       wr_idx0, wr_idx1;

  // Demand and allocation qualification.
  always_comb begin
    need           = {1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req};
    freelist_stall = (count_q < {4'b0, need}) && !flush_valid;
    fire           = (need != 2'd0) && !freelist_stall && !flush_valid;
  end

  // Responses are driven unconditionally; rename qualifies them with its own req.
  always_comb begin
    head_idx             = head_q[IdxW-1:0];
    head_idx1            = head_idx + idx_t'(1);
    instr0_freelist_resp = entry_q[head_idx];
    instr1_freelist_resp = instr0_freelist_req ? entry_q[head_idx1] : entry_q[head_idx];
  end

  // Releases are compacted: slot 1 lands at tail when slot 0 is idle.
  always_comb begin
    nfree   = {1'b0, commit_instr0_free_valid} + {1'b0, commit_instr1_free_valid};
    wr_idx0 = tail_q[IdxW-1:0];
    wr_idx1 = wr_idx0 + idx_t'(commit_instr0_free_valid);
  end

  // Next-state pointers; a flush restores head to the committed head including this cycle's commits.
  always_comb begin
    tail_d      = fl_ptr_inc(tail_q, nfree);
    arch_head_d = fl_ptr_inc(arch_head_q, nfree);
    head_d      = head_q;
    if (flush_valid) begin
      head_d = arch_head_d;
    end else if (fire) begin
      head_d = fl_ptr_inc(head_q, need);
    end
    count_d = tail_d - head_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        entry_q[i] <= PregW'(int'(LREG_NUM) + i);
      end
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(Depth);
      count_q     <= 6'(Depth);
    end else begin
      if (commit_instr0_free_valid) begin
        entry_q[wr_idx0] <= commit_instr0_free_preg;
      end
      if (commit_instr1_free_valid) begin
        entry_q[wr_idx1] <= commit_instr1_free_preg;
      end
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  assign freelist_count = count_q;

`ifdef FREELIST_STALL_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (freelist_stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign freelist_stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed vector table, hand-written corner sequences,
// and a randomized balanced alloc/free run against a queue model.
module tb_freelist;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       r0 = 1'b0, r1 = 1'b0;
  logic [5:0] resp0, resp1;
  logic       stall;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [5:0] p0 = '0, p1 = '0;
  logic       fl = 1'b0;
  logic [5:0] count;
`ifdef FREELIST_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  freelist dut (
    .clock                    (clock),
    .reset                    (reset),
    .instr0_freelist_req      (r0),
    .instr0_freelist_resp     (resp0),
    .instr1_freelist_req      (r1),
    .instr1_freelist_resp     (resp1),
    .freelist_stall           (stall),
    .commit_instr0_free_valid (v0),
    .commit_instr0_free_preg  (p0),
    .commit_instr1_free_valid (v1),
    .commit_instr1_free_preg  (p1),
    .flush_valid              (fl),
    .freelist_count           (count)
`ifdef FREELIST_STALL_CNT_EN
    ,
    .freelist_stall_cycles    (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    r0 = 0; r1 = 0; v0 = 0; v1 = 0; fl = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input logic a0, input logic a1, input logic f0, input int q0,
                      input logic f1, input int q1, input logic fx);
    @(negedge clock);
    r0 = a0; r1 = a1; v0 = f0; p0 = 6'(q0); v1 = f1; p1 = 6'(q1); fl = fx;
    #1;
  endtask

  // rst: reset before applying; e0/e1 < 0 means not checked
  typedef struct {
    logic rst;
    logic a0, a1, f0;
    int   q0;
    logic f1;
    int   q1;
    logic fx;
    logic stall;
    int   e0, e1, cnt;
  } vec_t;

  vec_t vecs[9];

  int free_q[$];
  int out_q[$];
  int tally;

  initial begin
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32, 32, 32};
    vecs[1] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 32, 33, 30};
    vecs[2] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 34, 35, 28};
    vecs[3] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 32, 32, 31};
    vecs[4] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 33, 34, 29};
    vecs[5] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 32, 33, 30};
    vecs[6] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 34, 35, 28};
    // commit frees preg 0 and flush in the same cycle: head -> arch_head = 1
    vecs[7] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 36, 37, 32};
    vecs[8] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 33, 34, 31};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].a0, vecs[i].a1, vecs[i].f0, vecs[i].q0, vecs[i].f1, vecs[i].q1, vecs[i].fx);
      chk($sformatf("v%0d stall", i), int'(stall), int'(vecs[i].stall));
      if (vecs[i].e0 >= 0) chk($sformatf("v%0d resp0", i), int'(resp0), vecs[i].e0);
      if (vecs[i].e1 >= 0) chk($sformatf("v%0d resp1", i), int'(resp1), vecs[i].e1);
      @(posedge clock); #1;
      chk($sformatf("v%0d count", i), int'(count), vecs[i].cnt);
    end

    // Drain to one entry, then stall on a double request.
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("drain resp0", int'(resp0), 62);
    @(posedge clock); #1;
    chk("drain count1", int'(count), 1);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("low stall", int'(stall), 1);
    chk("low resp0", int'(resp0), 63);
    @(posedge clock); #1;
    chk("low count held", int'(count), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("single nostall", int'(stall), 0);
    chk("single resp0", int'(resp0), 63);
    @(posedge clock); #1;
    chk("empty count", int'(count), 0);

    // Free at empty: no same-cycle bypass.
    step(1, 0, 1, 5, 1, 7, 0);
    chk("empty stall", int'(stall), 1);
    @(posedge clock); #1;
    chk("refill count", int'(count), 2);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("refill stall", int'(stall), 0);
    chk("refill resp0", int'(resp0), 5);
    chk("refill resp1", int'(resp1), 7);
    @(posedge clock); #1;
    chk("refill drained", int'(count), 0);

    // Random balanced traffic through pointer wrap.
    do_reset();
    free_q = {};
    out_q = {};
    for (int i = 32; i < 64; i++) free_q.push_back(i);
    tally = 0;
    for (int c = 0; c < 200; c++) begin
      logic a0, a1, f0, f1;
      int q0, q1, need, idx, hits, got;
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      f0 = 0; f1 = 0; q0 = 0; q1 = 0;
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, out_q.size() - 1);
        q0 = out_q[idx]; out_q.delete(idx); f0 = 1;
      end
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, out_q.size() - 1);
        q1 = out_q[idx]; out_q.delete(idx); f1 = 1;
      end
      step(a0, a1, f0, q0, f1, q1, 0);
      need = int'(a0) + int'(a1);
      chk("rnd stall", int'(stall), (free_q.size() < need) ? 1 : 0);
      if (free_q.size() < need) begin
        tally++;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if ((s == 0 && a0) || (s == 1 && a1)) begin
            got = (s == 0) ? int'(resp0) : int'(resp1);
            chk(s == 0 ? "rnd resp0" : "rnd resp1", got, free_q[0]);
            hits = 0;
            foreach (out_q[k]) if (out_q[k] == got) hits++;
            chk("rnd duplicate", hits, 0);
            out_q.push_back(free_q.pop_front());
          end
        end
      end
      if (f0) free_q.push_back(q0);
      if (f1) free_q.push_back(q1);
      @(posedge clock); #1;
      chk("rnd count", int'(count), free_q.size());
    end
`ifdef FREELIST_STALL_CNT_EN
    chk("stall cycles", int'(stall_cycles), tally);
`endif

    // Reset during traffic returns to the reset state in one edge.
    @(negedge clock);
    reset = 1; r0 = 1; r1 = 1; v0 = 1; p0 = 6'd3; fl = 1;
    @(posedge clock); #1;
    chk("midrst count", int'(count), 32);
    @(negedge clock);
    reset = 0; r0 = 0; r1 = 0; v0 = 0; fl = 0;
    #1;
    chk("midrst resp0", int'(resp0), 32);
`ifdef FREELIST_STALL_CNT_EN
    chk("midrst stall cycles", int'(stall_cycles), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the dual-issue rename stage. It is a circular queue of free physical register numbers and sits directly upstream of rename. It answers up to two allocation requests per cycle, combinationally and in program order, and accepts up to two released registers per cycle from commit. A separately tracked committed head lets a pipeline flush restore the speculative head in one cycle.

## Interface
Parameters:
- PREG_NUM, 64, total physical registers (matches `PREG_RANGE`)
- LREG_NUM, 32, architectural registers; queue depth FL_DEPTH = PREG_NUM - LREG_NUM = 32

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- instr0_freelist_req  in  1  rename slot 0 needs a new prd
- instr0_freelist_resp  out  `PREG_RANGE`  prd for slot 0
- instr1_freelist_req  in  1  rename slot 1 needs a new prd
- instr1_freelist_resp  out  `PREG_RANGE`  prd for slot 1
- freelist_stall  out  1  not enough free entries for this cycle's requests
- commit_instr0_free_valid  in  1  committed slot 0 wrote a register; releases its old_prd
- commit_instr0_free_preg  in  `PREG_RANGE`  old_prd released by slot 0
- commit_instr1_free_valid  in  1  same as slot 0, for commit slot 1
- commit_instr1_free_preg  in  `PREG_RANGE`  old_prd released by slot 1
- flush_valid  in  1  redirect; restore the speculative head
- freelist_count  out  6  free entries (0..32), registered
- freelist_stall_cycles  out  32  present only with FREELIST_STALL_CNT_EN

## Operation
- Storage: 32 x `PREG_RANGE` entry array.
- Pointers: head, tail and arch_head, each 6 bits (5-bit index plus wrap bit). count = tail - head, mod 64.
- Reset: entry[i] = 32 + i; head = 0; arch_head = 0; tail = {1'b1, 5'd0}; count = 32; stall_cycles = 0.
- Demand: need = req0 + req1. freelist_stall = (count < need) & ~flush_valid.
- Allocation fires when need != 0, ~freelist_stall and ~flush_valid.
- Response mapping:
  - instr0_freelist_resp = entry[head].
  - instr1_freelist_resp = req0 ? entry[head+1] : entry[head].
  - Responses are always driven, including under stall. Rename qualifies them with its req.
- Head update: on fire, head += need. On stall or flush, the speculative head does not advance from allocation.
- Release: slots are pushed in order, slot 0 first. Valid slots write entry[tail] and entry[tail+1] (compacted), then tail += v0 + v1.
- Committed head: arch_head += v0 + v1 every cycle. Each register-writing commit retires exactly one earlier allocation.
- Flush: head <= arch_head_next, which includes that cycle's commit increment. Allocation is ignored that cycle; frees are still processed.
- No bypass: a register freed in cycle N is allocatable from cycle N+1.
- Overflow: count never exceeds 32. A push while count + frees > 32 is illegal; the bench flags it.
- Wrap-around: index arithmetic is modulo 32, and the wrap bit distinguishes full from empty.

## Timing
- Allocation: zero-latency combinational response. Pointer state updates on the next clock edge.
- freelist_count: registered; reflects the state after the previous edge.
- Freed entries: visible to allocation one cycle after release.
- Flush: one cycle. In cycle N+1, head equals the committed head.
- Reset mid-operation: reset overrides all traffic and returns to the reset state in one edge.
- Simultaneous alloc 2 and free 2: count unchanged.

## Configuration
- FREELIST_STALL_CNT_EN:
  - Defined: the port freelist_stall_cycles exists. It is a saturating 32-bit counter, +1 on every cycle with freelist_stall = 1, and cleared by reset.
  - Undefined: the port and counter are absent, and the rest of the behaviour is identical.

## Structure
- Shared package:
  - FL_DEPTH, PREG_NUM, LREG_NUM
  - fl_ptr_t (6-bit pointer typedef)
  - Pointer-increment helper function
- No sub-module is needed. Entry storage, pointers and the stall counter stay in one module.

## Test plan
- Reset, then req0 = req1 = 1 for one cycle:
  - resp0 = 32, resp1 = 33.
  - Next cycle count = 30, and the next pair is 34/35.
- req1 only at reset: resp1 = 32 and head advances by 1. Then req0 + req1: 33/34.
- Drain to count = 1, then request 2:
  - freelist_stall = 1 and head unchanged.
  - req0 alone then succeeds, and count becomes 0.
- At count = 0, free 5 and 7 in one cycle:
  - Same-cycle request stalls.
  - Next cycle resp0 = 5 and resp1 = 7.
- Alloc 4 entries (32..35), commit 1 free, then flush:
  - head returns to arch_head = 1.
  - Next resp0 = 33, and count reflects the freed entry.
- Run 200 random balanced alloc/free cycles through pointer wrap:
  - No duplicate preg is ever outstanding, and count stays within 0..32.
  - With FREELIST_STALL_CNT_EN defined, the counter equals the bench's stall tally.
